// File: rtl/sr_ctrl_pkg.sv
// Shared types for the SR flag arbiter: FSM states and command opcodes.
package sr_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side command bus of the SR flag arbiter.
interface sr_flag_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int FW    = $clog2(NFLAG)
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    op;
  logic [NREQ*FW-1:0] idx;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [NFLAG-1:0]   flags;

  modport master (output req, op, idx, input gnt, busy, flags);
  modport slave  (input req, op, idx, output gnt, busy, flags);

endinterface

// File: rtl/sr_ff.sv
// Plain SR flip-flop without reset; S=R=1 is never driven by its only user.
module sr_ff (
  input  logic S,
  input  logic R,
  input  logic clk,
  output logic Q,
  output logic Q_bar
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (S && !R) begin
      q_d = 1'b1;
    end else if (R && !S) begin
      q_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign Q     = q_q;
  assign Q_bar = ~q_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that serialises set/clear commands onto a bank of sr_ff flags,
// driving at most one of S/R on one flag per cycle.
module sr_flag_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int FW    = $clog2(NFLAG)
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_flag_arbiter_if.slave   bus
);

  localparam int IW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]    win_id_q, win_id_d;
  logic             win_op_q, win_op_d;
  logic [FW-1:0]    win_idx_q, win_idx_d;
  logic             found;
  logic [IW-1:0]    win_sel;
  logic [NFLAG-1:0] s_vec, r_vec, q_vec, q_bar_unused;

  // Search starts at ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin : rr_select
    int cand;
    cand    = 0;
    found   = 1'b0;
    win_sel = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        win_sel = IW'(cand);
      end
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    win_id_d  = win_id_q;
    win_op_d  = win_op_q;
    win_idx_d = win_idx_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = DRIVE;
          win_id_d  = win_sel;
          win_op_d  = bus.op[win_sel];
          win_idx_d = bus.idx[win_sel*FW +: FW];
          for (int k = 0; k < NREQ; k++) begin
            gnt_d[k] = (int'(win_sel) == k);
          end
        end
      end
      DRIVE: begin
        state_d = IDLE;
        ptr_d   = (int'(win_id_q) == NREQ - 1) ? '0 : win_id_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset returns to IDLE and aborts any DRIVE in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  // Captured command: only consumed in DRIVE, so it needs no reset.
  always_ff @(posedge clk) begin
    win_id_q  <= win_id_d;
    win_op_q  <= win_op_d;
    win_idx_q <= win_idx_d;
  end

  // Out-of-range indices match no flag, so they drive nothing.
  always_comb begin : sr_drive
    s_vec = '0;
    r_vec = '0;
    if (!rst_n) begin
      r_vec = '1;
    end else if (state_q == DRIVE) begin
      for (int f = 0; f < NFLAG; f++) begin
        if (int'(win_idx_q) == f) begin
          s_vec[f] = (win_op_q == OP_SET);
          r_vec[f] = (win_op_q == OP_CLR);
        end
      end
    end
  end

  for (genvar g = 0; g < NFLAG; g++) begin : g_flag
    sr_ff u_ff (
      .S     (s_vec[g]),
      .R     (r_vec[g]),
      .clk   (clk),
      .Q     (q_vec[g]),
      .Q_bar (q_bar_unused[g])
    );
  end

  assign bus.gnt   = gnt_q;
  assign bus.busy  = (state_q == DRIVE);
  assign bus.flags = q_vec;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: directed commands queue their expected grant/flags.
module tb_sr_flag_arbiter;
  import sr_ctrl_pkg::*;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] flags;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  logic pend = 1'b0;
  logic [7:0] pend_flags = '0;
  int   last_gnt_cyc = 0;
  logic inv_on = 1'b0;

  sr_flag_arbiter_if #(.NREQ(4), .NFLAG(8), .FW(4)) bus ();

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .FW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input int r, input logic o, input int ix,
                       input logic [3:0] eg, input logic [7:0] ef, input int gap);
    exp_t e;
    logic [31:0] ixv;
    ixv = ix;
    bus.op[r]          = o;
    bus.idx[r*4 +: 4]  = ixv[3:0];
    bus.req[r]         = 1'b1;
    e.gnt = eg; e.flags = ef; e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || pend || bus.req != 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d grants outstanding, req=0x%0h", tag, sb_q.size(), bus.req);
      sb_q.delete();
      bus.req = '0;
    end
    @(negedge clk);
  endtask

  // Requesters drop req on the edge at which their grant is sampled.
  always @(negedge clk) begin
    bus.req = bus.req & ~bus.gnt;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (pend) begin
      chk("flags_after_drive", bus.flags, pend_flags);
      chk("busy_after_drive", bus.busy, 1'b0);
      pend = 1'b0;
    end
    if (bus.gnt != 0) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_grant: got 0x%0h, expected none", bus.gnt);
      end else begin
        e = sb_q.pop_front();
        chk("gnt", bus.gnt, e.gnt);
        chk("busy_in_drive", bus.busy, 1'b1);
        if (e.gap != 0) chk("grant_spacing", cyc - last_gnt_cyc, e.gap);
        pend_flags = e.flags;
        pend = 1'b1;
      end
      last_gnt_cyc = cyc;
    end
  end

  always @(negedge clk) begin : sr_invariant
    if (inv_on) begin
      n_chk++;
      if ((dut.s_vec & dut.r_vec) != 0) begin
        n_fail++;
        $display("FAIL s_and_r: got 0x%0h, expected 0x0", dut.s_vec & dut.r_vec);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t;
    bus.req = '0;
    bus.op  = '0;
    bus.idx = '0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    inv_on = 1'b1;
    chk("rst_flags", bus.flags, 8'h00);
    chk("rst_gnt", bus.gnt, 4'h0);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, OP_SET, 3, 4'b0001, 8'h08, 0);
    wait_idle("single_set");

    // Fresh reset so the pointer restarts at requester 0 for contention.
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_flags", bus.flags, 8'h00);
    chk("rst2_gnt", bus.gnt, 4'h0);
    chk("rst2_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, OP_SET, 0, 4'b0001, 8'h01, 0);
    issue(1, OP_SET, 1, 4'b0010, 8'h03, 2);
    issue(2, OP_SET, 2, 4'b0100, 8'h07, 2);
    issue(3, OP_SET, 3, 4'b1000, 8'h0F, 2);
    wait_idle("contention");

    issue(2, OP_SET, 4, 4'b0100, 8'h1F, 0);
    wait_idle("fair_pre");
    issue(3, OP_SET, 7, 4'b1000, 8'h9F, 0);
    issue(0, OP_SET, 6, 4'b0001, 8'hDF, 2);
    wait_idle("fairness");

    issue(1, OP_SET, 5, 4'b0010, 8'hFF, 0);
    wait_idle("set5");
    issue(1, OP_CLR, 5, 4'b0010, 8'hDF, 0);
    wait_idle("clr5");
    issue(2, OP_CLR, 9, 4'b0100, 8'hDF, 0);
    wait_idle("oor_clr");
    issue(3, OP_SET, 13, 4'b1000, 8'hDF, 0);
    wait_idle("oor_set");

    issue(1, OP_CLR, 0, 4'b0010, 8'h00, 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.gnt == 0 && t < 10);
    chk("midrst_grant_seen", bus.gnt, 4'b0010);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_gnt", bus.gnt, 4'h0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_flags", bus.flags, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, OP_SET, 2, 4'b0001, 8'h04, 0);
    issue(3, OP_SET, 6, 4'b1000, 8'h44, 2);
    wait_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
